mem_wb_skid_stage: RTL

//  Parametrised MEM->WB pipeline stage with valid/ready handshake, 2-entry skid buffer and sync flush.

---
 rtl/mem_wb_skid_stage_if.sv | 38 +++
 rtl/mem_wb_skid_stage.sv | 93 +++++++++
 2 files changed

// File: rtl/mem_wb_skid_stage_if.sv
// MEM->WB stage bus: upstream entry, held downstream entry, write-back port and occupancy.
// The stage uses the slave view; whoever feeds and drains it uses the master view.
interface mem_wb_skid_stage_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_addr;
    logic [XLEN-1:0] in_rdata;
    logic [RD_W-1:0] in_rd;
    logic            in_regw;
    logic            in_mem2r;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_addr;
    logic [XLEN-1:0] out_rdata;
    logic [RD_W-1:0] out_rd;
    logic            out_regw;
    logic            out_mem2r;

    logic [XLEN-1:0] wb_data;
    logic            wb_we;
    logic [1:0]      level;

    modport master (
        output in_valid, in_addr, in_rdata, in_rd, in_regw, in_mem2r, out_ready,
        input  in_ready, out_valid, out_addr, out_rdata, out_rd, out_regw, out_mem2r,
               wb_data, wb_we, level
    );

    modport slave (
        input  in_valid, in_addr, in_rdata, in_rd, in_regw, in_mem2r, out_ready,
        output in_ready, out_valid, out_addr, out_rdata, out_rd, out_regw, out_mem2r,
               wb_data, wb_we, level
    );
endinterface

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline register with 2-entry skid (MAIN drives outputs, SKID catches overflow); 1-cycle latency.
// Backpressure: in_ready/out_valid decode only the state register, so no out_ready->in_ready path.
module mem_wb_skid_stage #(
    parameter int XLEN           = 32,
    parameter int RD_W           = 5,
    parameter int ZERO_REG_GUARD = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    mem_wb_skid_stage_if.slave  bus
);
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] rdata;
        logic [RD_W-1:0] rd;
        logic            regw;
        logic            mem2r;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_ent;
    logic   in_fire;
    logic   out_fire;
    logic   rd_ok;

    assign in_ent   = '{addr: bus.in_addr, rdata: bus.in_rdata, rd: bus.in_rd,
                        regw: bus.in_regw, mem2r: bus.in_mem2r};
    assign bus.in_ready  = (state_q != TWO);
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.level     = state_q;
    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            // Drop everything; controls cleared so stale payloads can never write back.
            state_q      <= EMPTY;
            main_q.regw  <= 1'b0;
            main_q.mem2r <= 1'b0;
            skid_q.regw  <= 1'b0;
            skid_q.mem2r <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_q  <= in_ent;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_ent;
                    end else if (in_fire) begin
                        skid_q  <= in_ent;
                        state_q <= TWO;
                    end else if (out_fire) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.out_addr  = main_q.addr;
    assign bus.out_rdata = main_q.rdata;
    assign bus.out_rd    = main_q.rd;
    assign bus.out_regw  = main_q.regw;
    assign bus.out_mem2r = main_q.mem2r;

    assign rd_ok       = (ZERO_REG_GUARD == 0) || (main_q.rd != '0);
    assign bus.wb_data = main_q.mem2r ? main_q.rdata : main_q.addr;
    assign bus.wb_we   = out_fire & main_q.regw & rd_ok & ~flush;
endmodule
